// File: rtl/uart_pkg.sv
// Shared UART definitions: frame sizes, receiver state encoding and the parity
// helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

  // parity_type 0 gives even parity, 1 gives odd parity.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      parity_type);
    return parity_type ^ (^data);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: wraps at CLKS_PER_BIT-1, flags the mid-bit count and the
// last count of each bit period. A synchronous clear holds it at zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_half_tick,
  output logic o_full_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_half_tick = (r_cnt == HALF);
  assign o_full_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver for the 11-bit frame (start, 8 data LSB first, parity, stop).
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer in front of rx.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 27
) (
  input  logic           clk_3125,
  input  logic           rst_n,
  input  logic           rx,
  input  logic           parity_type,
  output logic [7:0]     rx_data,
  output logic           rx_valid,
  output logic           parity_err,
  output logic           frame_err,
  output uart_rx_state_t dbg_state
);

  logic w_rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = rx;
`endif

  uart_rx_state_t r_state, w_state_nxt;
  logic           r_rx_prev;
  logic           r_type;
  logic [3:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_par_bad;
  logic [7:0]     r_rx_data;
  logic           r_rx_valid;
  logic           r_parity_err;
  logic           r_frame_err;

  logic w_half, w_full;
  logic w_baud_clr, w_start_ok, w_shift_en, w_par_en, w_done;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk       (clk_3125),
    .i_rst_n     (rst_n),
    .i_clr       (w_baud_clr),
    .o_half_tick (w_half),
    .o_full_tick (w_full)
  );

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The baud counter sits at zero in IDLE and starts on the falling edge, so
  // its count equals the cycle number since the edge throughout START.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_clr  = 1'b0;
    w_start_ok  = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_clr = 1'b1;
        if (!w_rx && r_rx_prev) begin
          w_baud_clr  = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_half) begin
          w_baud_clr = 1'b1;
          if (!w_rx) begin
            w_start_ok  = 1'b1;
            w_state_nxt = DATA;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_full) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 4'(UART_DATA_BITS - 1)) begin
            w_state_nxt = PARITY;
          end
        end
      end
      PARITY: begin
        if (w_full) begin
          w_par_en    = 1'b1;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_full) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // rx_prev follows the line in every state, so a stop bit held low (break)
  // leaves it at 0 and IDLE will not re-arm until the line goes high again.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_prev    <= 1'b1;
      r_type       <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_prev  <= w_rx;
      r_rx_valid <= w_done;
      if (w_start_ok) begin
        r_type    <= parity_type;
        r_bit_cnt <= '0;
      end
      if (w_shift_en) begin
        r_shift   <= {w_rx, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_par_en) begin
        r_par_bad <= (w_rx != uart_parity(r_shift, r_type));
      end
      if (w_done) begin
        r_rx_data    <= r_shift;
        r_parity_err <= r_par_bad;
        r_frame_err  <= ~w_rx;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default bit period, default build
// (rx used directly).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = 27;
  localparam int H = (C - 1) / 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rx = 1'b1;
  logic           parity_type = 1'b0;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           parity_err;
  logic           frame_err;
  uart_rx_state_t dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // {parity_err, frame_err, data} plus the cycle rx_valid must land in
  logic [9:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [9:0] obs_q[$];
  int         obs_cyc_q[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_3125    (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .parity_type (parity_type),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor
  always @(negedge clk) begin
    if (rx_valid) begin
      obs_q.push_back({parity_err, frame_err, rx_data});
      obs_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // all drivers are entered and left #1 after a rising edge
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    int   t0;
    logic perr;
    t0   = cyc;
    perr = (p !== (parity_type ^ (^d)));
    exp_q.push_back({perr, ~s, d});
    exp_cyc_q.push_back(t0 + H + 10 * C + 1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic check_frame(input string tag);
    int         n;
    logic [9:0] o, e;
    int         oc, ec;
    n = 0;
    while (obs_q.size() == 0 && n < 2 * 11 * C) begin
      @(negedge clk);
      n++;
    end
    e  = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    chk({tag, "_seen"}, 32'(obs_q.size() > 0), 32'd1);
    if (obs_q.size() > 0) begin
      o  = obs_q.pop_front();
      oc = obs_cyc_q.pop_front();
      chk({tag, "_data"}, 32'(o[7:0]), 32'(e[7:0]));
      chk({tag, "_parity_err"}, 32'(o[9]), 32'(e[9]));
      chk({tag, "_frame_err"}, 32'(o[8]), 32'(e[8]));
      chk({tag, "_cycle"}, 32'(oc), 32'(ec));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'h00);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    int t0;

    // reset
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    // even parity, good frame: rx_valid at cycle 284
    parity_type = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(5);
    check_frame("even_a5");

    // odd parity selected, parity bit 0 -> parity error
    parity_type = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(5);
    check_frame("odd_a5");
    parity_type = 1'b0;

    // stop bit low, line held low for 3C: frame error, no re-arm while low
    send_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    check_frame("break_3c");
    chk("break_no_rearm", 32'(obs_q.size()), 32'd0);
    chk("break_state", 32'(dbg_state), 32'(IDLE));
    idle(2 * C);
    chk("break_recover_quiet", 32'(obs_q.size()), 32'd0);

    // 5-cycle low glitch: START through cycle H, IDLE at cycle H+1
    t0 = cyc;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    do @(negedge clk); while (cyc < t0 + H);
    chk("glitch_state_h", 32'(dbg_state), 32'(START));
    @(negedge clk);
    chk("glitch_state_h1", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;
    idle(12 * C);
    chk("glitch_no_valid", 32'(obs_q.size()), 32'd0);

    // back-to-back frames, zero idle: pulses 11C apart
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(5);
    check_frame("b2b_00");
    check_frame("b2b_ff");

    // reset during data bit 4 of 8'h5A
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
    rx = 1'b1;
    repeat (C / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midframe_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(12 * C);
    chk("midframe_reset_no_valid", 32'(obs_q.size()), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(5);
    check_frame("after_reset_5a");

    idle(C);
    chk("no_extra_valid", 32'(obs_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receiver for the team's 11-bit UART frame: start bit, 8 data bits (LSB first), parity bit, stop bit. It sits on the `clk_3125` domain, opposite the existing transmitter. It samples the serial line once per bit at mid-bit and delivers each byte with a one-cycle valid pulse and error flags. Parity is computed as `parity_type ^ (^data)`, so `parity_type` = 0 selects even parity and 1 selects odd.

## Interface
- `CLKS_PER_BIT`, default 27: `clk_3125` cycles per bit (3.125 MHz / 115200 baud). Legal range is 3 or more.
- `clk_3125`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx`  in  1  serial line; idles high.
- `parity_type`  in  1  0 = even, 1 = odd; latched at start-bit confirmation.
- `rx_data`  out  8  last received byte; holds until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when a frame completes (good or bad).
- `parity_err`  out  1  parity mismatch for the frame; valid with `rx_valid`, held until the next `rx_valid`.
- `frame_err`  out  1  stop bit sampled low; valid with `rx_valid`, held until the next `rx_valid`.

## Operation
- Definitions:
  - C = `CLKS_PER_BIT`; H = (C-1)/2, using integer division.
  - Bit counter is 4 bits wide. Baud counter is $clog2(C) bits wide and wraps to 0 at C-1.
- States are IDLE, START, DATA, PARITY and STOP.
- IDLE:
  - `rx_prev` tracks the line.
  - On `rx`=0 with `rx_prev`=1 (falling edge), clear the baud counter and go to START.
  - A line held low never re-arms; a high level must be seen first.
- START:
  - At baud count H, sample the line.
  - If low: latch `parity_type`, clear the counters and go to DATA.
  - If high (glitch): return to IDLE with no output.
- DATA:
  - Every C cycles, shift the sampled bit into bit [7] of the shift register, shifting right.
  - After the 8th bit, go to PARITY.
- PARITY: after C cycles, sample the parity bit and compare it with `latched_type ^ (^shift)`.
- STOP:
  - After C cycles, sample the stop bit.
  - In the next cycle: register `rx_data`, `parity_err` and `frame_err`, pulse `rx_valid`, and go to IDLE.
  - Returning mid-stop-bit allows back-to-back frames with zero idle time.
- A stop bit of 0 sets `frame_err`. IDLE then waits for `rx` to return high before re-arming (break handling).
- `rx_valid` fires on every completed frame; the error flags qualify it. A glitch abort in START produces no pulse.

## Timing
- Cycle 0 is the first cycle the (synchronized) `rx` is seen low in IDLE.
- Sample points:
  - Start bit at cycle H.
  - Data bit i (i = 0..7) at H + (i+1)·C.
  - Parity bit at H + 9C.
  - Stop bit at H + 10C.
- `rx_valid` is high in cycle H + 10C + 1, for exactly one cycle.
- Reset values:
  - State = IDLE, `rx_prev` = 1.
  - `rx_data` = 8'h00.
  - `rx_valid`, `parity_err` and `frame_err` = 0.
  - Synchronizer flops = 1.
- Reset asserted mid-frame: the block returns to IDLE at once, drops the partial byte and emits no `rx_valid`.
- `parity_type` changing mid-frame has no effect; the value latched at START is used.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `rx` passes through a 2-flop synchronizer, reset to 1, before any logic.
  - All latencies above are measured from the synchronizer output, so `rx_valid` lands 2 cycles later relative to the pin.
- Undefined: `rx` is used directly. This is for benches and for an already-synchronous source.

## Structure
- Shared package `uart_pkg` holds:
  - The `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - `UART_DATA_BITS` = 8 and `UART_FRAME_BITS` = 11.
  - The `uart_parity(data, parity_type)` function, shared with the transmitter.
- One sub-module, `uart_baud_tick`:
  - Counter with sync clear, a `half_tick` at count H and a `full_tick` at count C-1.
  - Instantiated once.

## Test plan
- C=27, even: frame for 8'hA5 with parity 0 and stop 1 -> `rx_valid` at cycle 284, `rx_data`=A5, both error flags 0.
- C=27, odd (`parity_type`=1): frame for 8'hA5 with parity 0 -> `rx_data`=A5, `parity_err`=1, `frame_err`=0.
- Frame for 8'h3C with stop bit 0, line then held low for 3C -> `frame_err`=1. No further `rx_valid` until the line goes high and a new start bit arrives.
- 5-cycle low glitch in IDLE -> no `rx_valid`, state back to IDLE by cycle 14.
- Back-to-back frames for 8'h00 and 8'hFF with no idle -> two `rx_valid` pulses 11C apart, with correct data and no errors.
- `rst_n` pulsed low during data bit 4 -> no `rx_valid`, outputs at reset values. A following clean frame for 8'h5A is received correctly.
